// File: rtl/clkdiv_pkg.sv
// ============================================================================
// clkdiv_pkg : shared state type, constants and helpers for the clock divider
// Revision   : 1.0
// ============================================================================
`default_nettype none

package clkdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    localparam int MIN_DIV = 2;

    // Number of high cycles of the posedge phase for ratio n.
    function automatic logic [31:0] div_high_len(input logic [31:0] n);
        return n >> 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clkdiv_core.sv
// ============================================================================
// clkdiv_core : divide counter, tick and div_out generation (CLKDIV_CTRL_HALFCYC_EN
//               adds the negedge phase for 50% duty on odd ratios)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module clkdiv_core
    import clkdiv_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    input  logic [CNT_W-1:0] n_act_i,
    output logic             tick_o,
    output logic             div_out_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [31:0]      w_half;
    logic             w_hi;

    assign w_half = div_high_len(32'(n_act_i));
    assign tick_o = run_i && (cnt_q == (n_act_i - CNT_W'(1)));
    assign w_hi   = run_i && (32'(cnt_q) < w_half);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!run_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef CLKDIV_CTRL_HALFCYC_EN
    // Half-cycle delayed copy of the high phase stretches odd ratios to 50% duty.
    logic neg_q;

    always_ff @(negedge clk) begin
        if (!rst || !run_i) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= w_hi;
        end
    end

    assign div_out_o = w_hi | (n_act_i[0] & neg_q);
`else
    assign div_out_o = w_hi;
`endif

endmodule

`default_nettype wire

// File: rtl/clkdiv_ctrl.sv
// ============================================================================
// clkdiv_ctrl : run-time ratio controller for an integer clock divider
//               (optional CLKDIV_CTRL_HALFCYC_EN handled in clkdiv_core)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             div_out,
    output logic             tick,
    output logic             busy
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] n_act_q;
    logic [CNT_W-1:0] n_act_d;
    logic [CNT_W-1:0] n_pend_q;
    logic [CNT_W-1:0] n_pend_d;
    logic             cfg_err_q;
    logic             w_xfer;
    logic             w_legal;
    logic             w_run;
    logic             w_tick;

    assign cfg_ready = (state_q != ST_PEND);
    assign busy      = (state_q != ST_IDLE);
    assign cfg_err   = cfg_err_q;
    assign tick      = w_tick;
    assign w_run     = busy;
    assign w_xfer    = cfg_valid & cfg_ready;
    assign w_legal   = (cfg_div >= CNT_W'(MIN_DIV));

    always_comb begin
        state_d  = state_q;
        n_act_d  = n_act_q;
        n_pend_d = n_pend_q;
        case (state_q)
            ST_IDLE: begin
                if (w_xfer && w_legal) begin
                    n_act_d = cfg_div;
                end
                if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A new ratio outranks a stop request landing on the same tick.
                if (w_xfer && w_legal) begin
                    n_pend_d = cfg_div;
                    state_d  = ST_PEND;
                end else if (w_tick && !enable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (w_tick) begin
                    n_act_d = n_pend_q;
                    state_d = enable ? ST_RUN : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            n_act_q   <= CNT_W'(DEFAULT_DIV);
            n_pend_q  <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_act_q   <= n_act_d;
            n_pend_q  <= n_pend_d;
            cfg_err_q <= w_xfer && !w_legal;
        end
    end

    clkdiv_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .run_i     (w_run),
        .n_act_i   (n_act_q),
        .tick_o    (w_tick),
        .div_out_o (div_out)
    );

endmodule

`default_nettype wire

// File: tb/tb_clkdiv_ctrl.sv
// ============================================================================
// tb_clkdiv_ctrl : scoreboard bench for clkdiv_ctrl against a period-level model
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_clkdiv_ctrl;

    localparam int CNT_W       = 8;
    localparam int DEFAULT_DIV = 3;

    logic             clk;
    logic             rst;
    logic             enable;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic             div_out;
    logic             tick;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    // expected {cfg_ready, cfg_err, div_out, tick, busy}
    logic [4:0] exp_q[$];

    // Reference model: a divider is either dividing or not, sits at some
    // position inside a period of length m_n, and may hold one queued ratio.
    bit m_run;
    bit m_pending;
    bit m_err;
    int m_n;
    int m_next;
    int m_pos;

    clkdiv_ctrl #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .div_out   (div_out),
        .tick      (tick),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_step(input bit r, input bit e, input bit v, input int d);
        bit xfer;
        bit legal;
        bit last;
        if (!r) begin
            m_run = 0; m_pending = 0; m_err = 0;
            m_n = DEFAULT_DIV; m_next = 0; m_pos = 0;
            return;
        end
        xfer  = v && !m_pending;
        legal = (d >= 2);
        m_err = xfer && !legal;
        last  = m_run && (m_pos == m_n - 1);
        if (!m_run) begin
            if (xfer && legal) m_n = d;
            if (e) begin
                m_run = 1;
                m_pos = 0;
            end
        end else if (last) begin
            m_pos = 0;
            if (m_pending) begin
                m_n = m_next;
                m_pending = 0;
                if (!e) m_run = 0;
            end else if (xfer && legal) begin
                m_next = d;
                m_pending = 1;
            end else if (!e) begin
                m_run = 0;
            end
        end else begin
            m_pos++;
            if (xfer && legal) begin
                m_next = d;
                m_pending = 1;
            end
        end
    endfunction

    function automatic logic [4:0] model_out();
        logic [4:0] o;
        o[4] = !m_pending;
        o[3] = m_err;
        o[2] = m_run && (m_pos < m_n / 2);
        o[1] = m_run && (m_pos == m_n - 1);
        o[0] = m_run;
        return o;
    endfunction

    task automatic drive(input bit r, input bit e, input bit v, input int d);
        @(negedge clk);
        rst       = r;
        enable    = e;
        cfg_valid = v;
        cfg_div   = CNT_W'(d);
        model_step(r, e, v, d);
        exp_q.push_back(model_out());
    endtask

    // Advance with enable high until the model reaches position p (bounded).
    task automatic run_to_pos(input int p);
        int guard;
        guard = 0;
        while (!(m_run && m_pos == p) && guard < 300) begin
            drive(1, 1, 0, 0);
            guard++;
        end
        if (guard >= 300) begin
            failures++;
            $display("FAIL run_to_pos: position %0d not reached, required %0d", m_pos, p);
        end
    endtask

    always @(posedge clk) begin
        logic [4:0] e;
        logic [4:0] got;
        #1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {cfg_ready, cfg_err, div_out, tick, busy};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL outputs @%0t: got rdy/err/div/tick/busy=%b required %b", $time, got, e);
            end
        end
    end

    initial begin
        bit en_r;
        bit stopping;
        int guard;
        rst = 1'b0; enable = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        model_step(0, 0, 0, 0);

        // reset, then default ratio 3
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(1, 1, 0, 0);
        repeat (9) drive(1, 1, 0, 0);
        // change to 5 mid-period, then 4 exactly on the tick cycle
        run_to_pos(1);
        drive(1, 1, 1, 5);
        repeat (12) drive(1, 1, 0, 0);
        run_to_pos(m_n - 1);
        drive(1, 1, 1, 4);
        repeat (14) drive(1, 1, 0, 0);
        // illegal ratios
        drive(1, 1, 1, 1);
        drive(1, 1, 0, 0);
        drive(1, 1, 1, 0);
        repeat (8) drive(1, 1, 0, 0);
        // ratio 6, then stop at the start of a period
        drive(1, 1, 1, 6);
        repeat (16) drive(1, 1, 0, 0);
        run_to_pos(0);
        repeat (8) drive(1, 0, 0, 0);
        // reset while a ratio is pending
        drive(1, 1, 0, 0);
        run_to_pos(1);
        drive(1, 1, 1, 7);
        drive(1, 1, 0, 0);
        drive(0, 1, 0, 0);
        repeat (10) drive(1, 1, 0, 0);

        // randomized traffic
        en_r = 1; stopping = 0;
        for (int i = 0; i < 4000; i++) begin
            bit v;
            int d;
            int k;
            bit r;
            r = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
            if (!m_run) stopping = 0;
            if (stopping) begin
                en_r = 0;
            end else if (!m_run) begin
                en_r = ($urandom_range(0, 9) < 4);
            end else begin
                en_r = 1;
            end
            v = ($urandom_range(0, 9) == 0);
            if (m_run && !stopping && !v && $urandom_range(0, 49) == 0) begin
                stopping = 1;
                en_r = 0;
            end
            if (stopping) v = 0;
            k = $urandom_range(0, 9);
            if (k == 0)      d = 0;
            else if (k == 1) d = 1;
            else if (k == 2) d = m_n;
            else if (k == 3) d = 2;
            else             d = $urandom_range(2, 12);
            if (!r) stopping = 0;
            drive(r, en_r, v, d);
        end
        drive(1, 0, 0, 0);

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
